// File: rtl/sccb_pkg.sv
// Shared SCCB types: FSM state encoding, bus constants and state-class helpers.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_VAL,
    ST_VAL_ACK,
    ST_IGNORE
  } sccb_state_e;

  localparam logic [7:0] SCCB_ID_OV7670_W   = 8'h42;
  localparam int         SCCB_BITS_PER_BYTE = 8;

  function automatic logic is_ack_state(input sccb_state_e s);
    return (s == ST_ID_ACK) || (s == ST_REG_ACK) || (s == ST_VAL_ACK);
  endfunction

  function automatic logic is_data_state(input sccb_state_e s);
    return (s == ST_ID) || (s == ST_REG) || (s == ST_VAL);
  endfunction

  // States between a matched START and the end of the value ACK.
  function automatic logic in_transaction(input sccb_state_e s);
    return (s != ST_IDLE) && (s != ST_IGNORE);
  endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// SIOC/SIOD synchronizer and bus-event decoder; events are combinational on the
// last sync stage and its registered copy (SYNC_STAGES+1 cycles from the pin).
module sccb_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_s,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_p;
  logic                   r_sda_p;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Preset to the idle bus level so reset never manufactures an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign o_sda_s    = w_sda_s;
  assign o_scl_rise = w_scl_s & ~r_scl_p;
  assign o_scl_fall = ~w_scl_s & r_scl_p;
  assign o_start    = w_scl_s & r_scl_p & r_sda_p & ~w_sda_s;
  assign o_stop     = w_scl_s & r_scl_p & ~r_sda_p & w_sda_s;

endmodule

// File: rtl/sccb_responder.sv
// Write-only SCCB target: decodes START/ID/REG/VAL/STOP, ACKs its own ID and
// emits one wr_valid strobe per completed register write.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_ID_OV7670_W,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err
);

  sccb_state_e r_state;
  sccb_state_e w_state_nxt;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_addr;
  logic       r_ack_on;
  logic       r_wr_done;
  logic       r_wr_valid;
  logic       r_err;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_byte_done;

  sccb_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda_s    (w_sda_s),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte      = {r_shift, w_sda_s};
  assign w_byte_done = w_scl_rise && is_data_state(r_state) &&
                       (r_bit_cnt == 3'(SCCB_BITS_PER_BYTE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The ACK states advance on their second SCL fall: the first one starts the drive.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ID;
    end else begin
      case (r_state)
        ST_ID:      if (w_byte_done) w_state_nxt = (w_byte == DEV_ID) ? ST_ID_ACK : ST_IGNORE;
        ST_ID_ACK:  if (w_scl_fall && r_ack_on) w_state_nxt = ST_REG;
        ST_REG:     if (w_byte_done) w_state_nxt = ST_REG_ACK;
        ST_REG_ACK: if (w_scl_fall && r_ack_on) w_state_nxt = ST_VAL;
        ST_VAL:     if (w_byte_done) w_state_nxt = ST_VAL_ACK;
        ST_VAL_ACK: if (w_scl_fall && r_ack_on) w_state_nxt = ST_IGNORE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    sda_oe = is_ack_state(r_state) && r_ack_on;
    busy   = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_ack_on   <= 1'b0;
      r_wr_done  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_err      <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      r_err      <= 1'b0;
      if (w_stop || w_start) begin
        // Abandoning a transaction before its write landed is the only error case.
        r_err     <= in_transaction(r_state) && !r_wr_done;
        r_bit_cnt <= '0;
        r_ack_on  <= 1'b0;
        r_wr_done <= 1'b0;
      end else begin
        if (w_scl_rise && is_data_state(r_state)) begin
          r_shift   <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_byte_done && (r_state == ST_REG)) begin
          r_addr <= w_byte;
        end
        if (w_byte_done && (r_state == ST_VAL)) begin
          r_wr_addr  <= r_addr;
          r_wr_data  <= w_byte;
          r_wr_valid <= 1'b1;
          r_wr_done  <= 1'b1;
        end
        if (w_scl_fall && is_ack_state(r_state)) begin
          r_ack_on <= !r_ack_on;
        end
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign err      = r_err;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench: bit-bangs an SCCB master onto an open-drain SIOD model.
module tb_sccb_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int q;
  int wr_cnt = 0;
  int err_cyc = 0;
  int oe_cyc = 0;
  logic [15:0] wr_log[$];

  assign sda_bus = m_sda & ~sda_oe;

  sccb_responder #(
    .DEV_ID      (8'h42),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt = wr_cnt + 1;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (err) err_cyc = err_cyc + 1;
    if (sda_oe) oe_cyc = oe_cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    wait_clk(q); m_sda = b;
    wait_clk(q); m_scl = 1'b1;
    wait_clk(2 * q); m_scl = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7 - i]);
  endtask

  task automatic ack_slot(output logic oe_mid);
    wait_clk(q); m_sda = 1'b1;
    wait_clk(q); m_scl = 1'b1;
    wait_clk(q); oe_mid = sda_oe;
    wait_clk(q); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic oe_mid);
    send_bits(v, 8);
    ack_slot(oe_mid);
  endtask

  task automatic do_start;
    wait_clk(q); m_sda = 1'b1;
    wait_clk(2 * q); m_scl = 1'b1;
    wait_clk(2 * q); m_sda = 1'b0;
    wait_clk(2 * q); m_scl = 1'b0;
  endtask

  task automatic do_stop;
    wait_clk(q); m_sda = 1'b0;
    wait_clk(q); m_scl = 1'b1;
    wait_clk(2 * q); m_sda = 1'b1;
    wait_clk(2 * q);
  endtask

  initial begin
    logic a0, a1, a2, a3, a4, a5;
    int   wr0, err0, oe0;

    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; q = 64;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    // Write 42/12/80 at SCL period 256 clk.
    wr0 = wr_cnt; err0 = err_cyc;
    do_start;
    chk("t1_busy_hi", 32'(busy), 1);
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    chk("t1_acks", {29'd0, a0, a1, a2}, 32'h7);
    do_stop;
    wait_clk(4);
    chk("t1_wr_cnt", 32'(wr_cnt - wr0), 1);
    chk("t1_wr_log", 32'(wr_log[wr_log.size() - 1]), 32'h1280);
    chk("t1_wr_addr", 32'(wr_addr), 32'h12);
    chk("t1_wr_data", 32'(wr_data), 32'h80);
    chk("t1_err", 32'(err_cyc - err0), 0);
    chk("t1_busy_lo", 32'(busy), 0);

    // Foreign ID 44: no ACK anywhere, no write, no error.
    q = 4;
    wr0 = wr_cnt; err0 = err_cyc; oe0 = oe_cyc;
    do_start;
    send_byte(8'h44, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    do_stop;
    wait_clk(4);
    chk("t2_ack_id", 32'(a0), 0);
    chk("t2_oe_cycles", 32'(oe_cyc - oe0), 0);
    chk("t2_wr_cnt", 32'(wr_cnt - wr0), 0);
    chk("t2_err", 32'(err_cyc - err0), 0);

    // STOP after 4 value bits: single-cycle err, write outputs untouched.
    wr0 = wr_cnt; err0 = err_cyc;
    do_start;
    send_byte(8'h42, a0);
    send_byte(8'h3A, a1);
    send_bits(8'h04, 4);
    do_stop;
    wait_clk(4);
    chk("t3_err_cycles", 32'(err_cyc - err0), 1);
    chk("t3_wr_cnt", 32'(wr_cnt - wr0), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_wr_addr", 32'(wr_addr), 32'h12);
    chk("t3_wr_data", 32'(wr_data), 32'h80);

    // Repeated START after the register byte, then a full 42/11/01.
    wr0 = wr_cnt; err0 = err_cyc;
    do_start;
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    do_start;
    chk("t4_err_at_rs", 32'(err_cyc - err0), 1);
    send_byte(8'h42, a2);
    send_byte(8'h11, a3);
    send_byte(8'h01, a4);
    do_stop;
    wait_clk(4);
    chk("t4_err_total", 32'(err_cyc - err0), 1);
    chk("t4_wr_cnt", 32'(wr_cnt - wr0), 1);
    chk("t4_wr_log", 32'(wr_log[wr_log.size() - 1]), 32'h1101);

    // Reset pulse during the REG ACK clock, then a clean 42/15/02.
    wr0 = wr_cnt; err0 = err_cyc;
    do_start;
    send_byte(8'h42, a0);
    send_bits(8'h15, 8);
    wait_clk(q); m_sda = 1'b1;
    wait_clk(q); m_scl = 1'b1;
    wait_clk(q);
    chk("t5_oe_before", 32'(sda_oe), 1);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    chk("t5_oe_after", 32'(sda_oe), 0);
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_wr_addr_rst", 32'(wr_addr), 0);
    wait_clk(q); m_scl = 1'b0;
    wait_clk(4 * q);
    do_start;
    send_byte(8'h42, a0);
    send_byte(8'h15, a1);
    send_byte(8'h02, a2);
    do_stop;
    wait_clk(4);
    chk("t5_acks", {29'd0, a0, a1, a2}, 32'h7);
    chk("t5_wr_cnt", 32'(wr_cnt - wr0), 1);
    chk("t5_wr_log", 32'(wr_log[wr_log.size() - 1]), 32'h1502);
    chk("t5_err", 32'(err_cyc - err0), 0);

    // Back-to-back writes at SCL period 8 clk.
    q = 2;
    wr0 = wr_cnt; err0 = err_cyc;
    do_start;
    send_byte(8'h42, a0);
    send_byte(8'h40, a1);
    send_byte(8'hD0, a2);
    do_stop;
    do_start;
    send_byte(8'h42, a3);
    send_byte(8'h8C, a4);
    send_byte(8'h00, a5);
    do_stop;
    wait_clk(4);
    chk("t6_acks", {26'd0, a0, a1, a2, a3, a4, a5}, 32'h3F);
    chk("t6_wr_cnt", 32'(wr_cnt - wr0), 2);
    chk("t6_wr_first", 32'(wr_log[wr_log.size() - 2]), 32'h40D0);
    chk("t6_wr_second", 32'(wr_log[wr_log.size() - 1]), 32'h8C00);
    chk("t6_err", 32'(err_cyc - err0), 0);
    chk("t6_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB/I2C write-only target. Oversamples the SIOC/SIOD bus on the system clock and decodes 3-phase write transactions: START, ID, register, value, STOP.
- Acknowledges its own device ID and presents each completed register write as a one-cycle strobe.
- Used as the camera-side model for bench loop-back of the camera configuration path, and as a synthesizable config target on the FPGA.

Parameters:
- DEV_ID, 8'h42: full 8-bit write ID (LSB = 0) that this target answers to.
- SYNC_STAGES, 2: synchronizer flops on scl_i/sda_i; legal range 2..3.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst_n  input  1  synchronous active-low reset.
- scl_i  input  1  raw SIOC from pad.
- sda_i  input  1  raw SIOD from pad (bus value, including own drive).
- sda_oe  output  1  1 = pull SIOD low (open-drain). Pad drives 0 when sda_oe = 1, Z otherwise.
- wr_valid  output  1  one-cycle pulse: a write completed.
- wr_addr  output  8  register address; valid while wr_valid = 1, held until the next write.
- wr_data  output  8  register value; same validity as wr_addr.
- busy  output  1  1 from a detected START to a detected STOP.
- err  output  1  one-cycle pulse: STOP or repeated START arrived mid-transaction.

Behaviour:
- Reset (rst_n = 0 at a clk edge): sda_oe = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0, err = 0, state = IDLE. The synchronizers preset to 1 so no false edge is seen after reset. Reset mid-transfer releases SDA immediately (next edge).
- Sampling: scl_s/sda_s are the last synchronizer stage; scl_p/sda_p are registered copies of them.
  - scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
  - START = scl_s & scl_p & sda_p & ~sda_s.
  - STOP = scl_s & scl_p & ~sda_p & sda_s.
  - Detection latency is SYNC_STAGES + 1 cycles from the pin change.
- Data sampling: on scl_rise, shift sda_s into an 8-bit shift register, MSB first. A 3-bit bit counter increments on each scl_rise. Byte completes on the 8th scl_rise.
- States: IDLE, ID, ID_ACK, REG, REG_ACK, VAL, VAL_ACK, IGNORE.
  - IDLE: START -> ID; busy = 1; bit counter cleared.
  - ID: after 8 bits, if byte == DEV_ID -> ID_ACK; otherwise -> IGNORE (no ACK).
  - xx_ACK: on the scl_fall ending bit 8, assert sda_oe. On the next scl_fall (end of ACK clock), deassert sda_oe and advance.
    - ID_ACK -> REG; latch nothing.
    - REG_ACK -> VAL; the REG byte is captured into an internal address register at REG byte completion.
    - VAL_ACK -> IGNORE. On VAL byte completion (8th scl_rise), wr_addr/wr_data load, and wr_valid pulses for 1 cycle in that same cycle.
  - IGNORE: sda_oe = 0. Further bytes are not ACKed and produce no write. Wait for STOP or START.
- STOP in any state: -> IDLE, busy = 0, sda_oe = 0. err pulses if the state was ID..VAL_ACK with no wr_valid yet issued in this transaction. STOP in IGNORE after a completed write, or after an ID mismatch, is not an error.
- Repeated START in any non-IDLE state: -> ID, counter cleared, sda_oe = 0. err pulses under the same rule as STOP.
- Simultaneous START/STOP with scl_rise in the same cycle cannot occur, because START/STOP require scl steady high. START/STOP take priority over all other transitions.
- The ACK slot bit sampled on the 9th scl_rise is not shifted into the byte.
- A write-ID with R/W = 1 never matches, since DEV_ID LSB = 0, so reads are NACKed.

Decomposition:
- Shared package sccb_pkg:
  - state enum (8 states);
  - constants SCCB_ID_OV7670_W = 8'h42 and SCCB_BITS_PER_BYTE = 8.
- Sub-module sccb_bus_sync: synchronizers plus scl_rise/scl_fall/start/stop edge decode. Reused by any future bus monitor.

Test Plan:
- ID/addr/value bytes 42/12/80 sent with SCL period 256 clk, STOP -> sda_oe low during each of the 3 ACK clocks. One wr_valid pulse with wr_addr = 12, wr_data = 80. err = 0; busy 1 -> 0.
- ID byte 44 -> no ACK (sda_oe stays 0 for the whole transaction), no wr_valid, no err.
- 42/3A/04 then STOP after only 4 VAL bits -> no wr_valid, err pulse 1 cycle, busy = 0, wr_addr/wr_data keep their prior values.
- 42/12 then repeated START then 42/11/01/STOP -> err pulse at the repeated START. Exactly one wr_valid, with addr = 11, data = 01.
- rst_n low for 1 cycle during the REG ACK clock -> sda_oe = 0 next cycle, state IDLE. The following full 42/15/02 write succeeds.
- Back-to-back writes 42/40/D0 and 42/8C/00 at the minimum ratio (SCL period 8 clk) -> two wr_valid pulses in order, with correct values.
